// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and state encoding for the FIR coefficient
//               loader and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int             NTAPS        = 4;
    localparam int             CW           = 8;
    localparam int             TIMEOUT      = 255;
    localparam logic [7:0]     CFG_HDR_LOAD = 8'hC5;
    localparam logic [7:0]     RESET_COEF   = 8'h01;

    // Loader FSM encoding; CHECK is only reachable in checksum builds
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        CHECK     = 2'd2,
        WAIT_TICK = 2'd3
    } cfg_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/cfg_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : cfg_timeout_ctr
// Description : Idle-cycle watchdog for an in-progress configuration frame.
//               o_expired is high in the cycle whose clock edge would bring
//               the idle count up to TIMEOUT, so the owner aborts on exactly
//               that edge. The count restarts after expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit     = i_enable && !i_clear && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_expired = w_hit;

    // Count idle cycles; any accepted byte or leaving the frame restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_hit) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : cfg_timeout_ctr
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_loader
// Description : Byte-serial framed coefficient loader. Frames (header C5,
//               NTAPS taps, optional XOR checksum) land in a shadow bank and
//               are committed to the active bank on the next sample_en so
//               the FIR core never sees a mix of old and new taps.
//               Build option: FIR_CFG_CHECKSUM_EN adds the checksum byte and
//               the CHECK state.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int              NTAPS      = fir_pkg::NTAPS,
    parameter int              CW         = fir_pkg::CW,
    parameter int              TIMEOUT    = fir_pkg::TIMEOUT,
    parameter logic [CW-1:0]   RESET_COEF = CW'(fir_pkg::RESET_COEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [CW-1:0]         cfg_data,
    output logic                  cfg_ready,
    input  logic                  sample_en,
    output logic [NTAPS*CW-1:0]   coef,
    output logic                  coef_update,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    cfg_state_t                  r_state;
    logic [IW-1:0]               r_idx;
    logic [NTAPS-1:0][CW-1:0]    r_shadow;
    logic [NTAPS-1:0][CW-1:0]    r_coef;
    logic                        r_coef_update;
    logic                        r_err;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_in_frame;
    logic                        w_expired;

    assign w_ready    = (r_state != WAIT_TICK);
    assign w_accept   = cfg_valid && w_ready;
    assign w_in_frame = (r_state == LOAD) || (r_state == CHECK);

    assign cfg_ready   = w_ready;
    assign coef        = r_coef;
    assign coef_update = r_coef_update;
    assign busy        = (r_state != IDLE);
    assign err         = r_err;

    cfg_timeout_ctr #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept || !w_in_frame),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

`ifdef FIR_CFG_CHECKSUM_EN
    logic [CW-1:0] w_csum;

    // XOR of all staged taps, compared against the trailing checksum byte
    always_comb begin
        w_csum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_csum = w_csum ^ r_shadow[i];
        end
    end
`endif

    // Frame FSM, shadow staging and atomic commit to the active bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_coef        <= {NTAPS{RESET_COEF}};
            r_coef_update <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_coef_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Non-header bytes are dropped silently to resync
                    if (w_accept && (cfg_data == CW'(CFG_HDR_LOAD))) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_shadow[r_idx] <= cfg_data;
                        if (r_idx == IW'(NTAPS - 1)) begin
`ifdef FIR_CFG_CHECKSUM_EN
                            r_state <= CHECK;
`else
                            r_state <= WAIT_TICK;
`endif
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else if (w_expired) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end
                end
`ifdef FIR_CFG_CHECKSUM_EN
                CHECK: begin
                    if (w_accept) begin
                        if (cfg_data == w_csum) begin
                            r_state <= WAIT_TICK;
                        end else begin
                            r_state <= IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end
                end
`endif
                WAIT_TICK: begin
                    if (sample_en) begin
                        r_coef        <= r_shadow;
                        r_coef_update <= 1'b1;
                        r_err         <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : fir_coeff_loader
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_coeff_loader
// Description : Self-checking bench for fir_coeff_loader. A frame-level model
//               (byte queue + pending flag) predicts every output each cycle;
//               directed frames pin the model to hand-computed values, then
//               randomized traffic exercises resync, gaps and commits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_loader;

    localparam int NT = 4;
    localparam int TO = 255;
`ifdef FIR_CFG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        sample_en;
    logic [31:0] coef;
    logic        coef_update;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_coeff_loader #(
        .NTAPS      (NT),
        .CW         (8),
        .TIMEOUT    (TO),
        .RESET_COEF (8'h01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .sample_en   (sample_en),
        .coef        (coef),
        .coef_update (coef_update),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_coef;
    logic        m_upd;
    logic        m_err;
    bit          m_in_frame;   // header seen, collecting bytes
    bit          m_pending;    // full good frame waiting for a sample tick
    logic [7:0]  m_frame[$];
    int          m_idle;

    task automatic model_reset();
        m_coef     = 32'h01010101;
        m_upd      = 1'b0;
        m_err      = 1'b0;
        m_in_frame = 0;
        m_pending  = 0;
        m_frame.delete();
        m_idle     = 0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_step();
        logic [7:0] x;
        m_upd = 1'b0;
        if (m_pending) begin
            if (sample_en) begin
                for (int i = 0; i < NT; i++) m_coef[i*8 +: 8] = m_frame[i];
                m_upd     = 1'b1;
                m_err     = 1'b0;
                m_pending = 0;
            end
        end else if (m_in_frame) begin
            if (cfg_valid) begin
                m_frame.push_back(cfg_data);
                m_idle = 0;
                if (m_frame.size() == NT + CS) begin
                    m_in_frame = 0;
                    x = 8'h00;
                    for (int i = 0; i < NT; i++) x = x ^ m_frame[i];
                    if (CS == 0 || m_frame[NT] == x) m_pending = 1;
                    else m_err = 1'b1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_in_frame = 0;
                    m_err      = 1'b1;
                end
            end
        end else if (cfg_valid && cfg_data == 8'hC5) begin
            m_in_frame = 1;
            m_frame.delete();
            m_idle = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, then step the model
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("coef",        coef,        m_coef);
            check("coef_update", {31'd0, coef_update}, {31'd0, m_upd});
            check("busy",        {31'd0, busy},        {31'd0, (m_in_frame || m_pending)});
            check("cfg_ready",   {31'd0, cfg_ready},   {31'd0, !m_pending});
            check("err",         {31'd0, err},         {31'd0, m_err});
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    // Each call occupies exactly one clock cycle (inputs applied #1 after edge)
    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        cfg_valid = v;
        cfg_data  = d;
        sample_en = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [31:0] taps, input bit bad_csum);
        logic [7:0] x;
        x = taps[7:0] ^ taps[15:8] ^ taps[23:16] ^ taps[31:24];
        drive(1'b1, 8'hC5, 1'b0);
        for (int i = 0; i < NT; i++) drive(1'b1, taps[i*8 +: 8], 1'b0);
        if (CS != 0) drive(1'b1, bad_csum ? (x ^ 8'h01) : x, 1'b0);
    endtask

    // Randomized frame with gaps, junk, and ignored sample strobes
    task automatic rand_frame();
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        drive(1'b1, 8'hC5, 1'($urandom_range(0, 1)));
        for (int i = 0; i < NT; i++) begin
            idle($urandom_range(0, 2));
            b = 8'($urandom);
            x = x ^ b;
            drive(1'b1, b, 1'($urandom_range(0, 1)));
        end
        if (CS != 0) begin
            if ($urandom_range(0, 7) == 0) x = x ^ 8'($urandom_range(1, 255));
            drive(1'b1, x, 1'b0);
        end
        for (int i = 0; i < int'($urandom_range(0, 4)); i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        drive(1'($urandom_range(0, 1)), 8'hC5, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        sample_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_coef",  coef, 32'h01010101);
        check("rst_err",   {31'd0, err},       32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        idle(2);

        // Basic frame, commit 3 cycles later
        send_frame(32'h40302010, 1'b0);
        check("wait_ready", {31'd0, cfg_ready}, 32'd0);
        check("wait_busy",  {31'd0, busy},      32'd1);
        idle(3);
        check("pre_commit_coef", coef, 32'h01010101);
        drive(1'b0, 8'h00, 1'b1);
        check("commit_coef",   coef,  32'h40302010);
        check("model_coef",    m_coef, 32'h40302010);
        check("commit_pulse",  {31'd0, coef_update}, 32'd1);
        check("commit_busy",   {31'd0, busy},        32'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("pulse_drop",    {31'd0, coef_update}, 32'd0);

        // Resync: junk 00 dropped, C5 inside the frame is tap data
        drive(1'b1, 8'h00, 1'b0);
        check("junk_err",  {31'd0, err},  32'd0);
        check("junk_busy", {31'd0, busy}, 32'd0);
        send_frame(32'h04C50301, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check("c5_tap_coef", coef, 32'h04C50301);

`ifdef FIR_CFG_CHECKSUM_EN
        // Bad checksum: error, bank untouched, then a good frame clears it
        send_frame(32'h40302010, 1'b1);
        check("badcs_err",  {31'd0, err},  32'd1);
        check("badcs_busy", {31'd0, busy}, 32'd0);
        check("badcs_coef", coef, 32'h04C50301);
        send_frame(32'h40302010, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check("recover_coef", coef, 32'h40302010);
        check("recover_err",  {31'd0, err}, 32'd0);
`endif

        // Timeout after header + 2 data bytes
        drive(1'b1, 8'hC5, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        idle(TO - 1);
        check("to_pre_busy", {31'd0, busy}, 32'd1);
        check("to_pre_err",  {31'd0, err},  32'd0);
        idle(1);
        check("to_err",  {31'd0, err},  32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_coef", coef, (CS != 0) ? 32'h40302010 : 32'h04C50301);

        // Asynchronous reset mid-frame, then a full frame loads
        drive(1'b1, 8'hC5, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b1, 8'hCC, 1'b0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("arst_coef", coef, 32'h01010101);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(32'h8877FF00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check("post_rst_coef", coef, 32'h8877FF00);

        // Randomized traffic: frames, junk bytes and stray strobes
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                    drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) == 0 ? 8'hC5 : 8'($urandom)),
                          1'($urandom_range(0, 1)));
            end
            rand_frame();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fir_coeff_loader
`default_nettype wire
